ir_command_decoder: RTL
=======================

# ir_command_decoder

Consumes the raw 32-bit NEC frames produced by the IR receiver (`i_DATA_READY` / `i_DATA`) and validates the complement bytes and the optional address. It suppresses and flags auto-repeat key holds, and queues decoded {address, command} pairs in a small first-word-fall-through FIFO for the host-side logic. It sits directly downstream of the IR receiver and is the only consumer of its output.

## Interface
- `ADDR_CHECK`, default 1: when 1, reject frames whose byte 1 is not the bitwise complement of byte 0.
- `ADDR_MATCH_EN`, default 0: when 1, accept only frames whose address equals `ADDR_VALUE`.
- `ADDR_VALUE`, default 8'h00: accepted address when `ADDR_MATCH_EN`=1.
- `HOLD_WINDOW`, default 6000000: cycles (120 ms at 50 MHz) in which an identical frame counts as a key hold.
- `FIFO_DEPTH`, default 4: queue entries; must be a power of two, at least 2.
- `i_CLOCK_POS` in 1: clock, rising edge.
- `i_RESET_NEG` in 1: reset, asynchronous, active-low.
- `i_DATA_READY` in 1: frame-available level from the receiver.
- `i_DATA` in 32: raw frame. Byte layout: [7:0] address, [15:8] ~address, [23:16] command, [31:24] ~command.
- `i_CMD_POP` in 1: consumer takes the head entry.
- `o_CMD_VALID` out 1: FIFO not empty.
- `o_ADDR` out 8: head entry address.
- `o_CMD` out 8: head entry command.
- `o_HOLD` out 1: key currently held.
- `o_ERROR` out 1: one-cycle pulse when a frame is rejected.
- `o_OVERFLOW` out 1: one-cycle pulse when a valid frame is dropped because the FIFO is full.

## Operation
- FSM states: IDLE, CHECK, PUSH, REPEAT, REJECT, WAIT_RELEASE.
- IDLE: when `i_DATA_READY`=1, latch `i_DATA` into the frame register and go to CHECK.
- CHECK: evaluate the frame.
  - Invalid if [31:24] != ~[23:16].
  - Invalid if `ADDR_CHECK`=1 and [15:8] != ~[7:0].
  - Invalid if `ADDR_MATCH_EN`=1 and [7:0] != `ADDR_VALUE`.
  - Invalid → REJECT.
  - Valid, and {addr,cmd} equals the last accepted pair, and hold counter < `HOLD_WINDOW` → REPEAT.
  - Any other valid frame → PUSH.
- PUSH:
  - Write {addr,cmd} to the FIFO.
  - If the FIFO is full and no pop occurs this cycle, drop the frame and pulse `o_OVERFLOW`.
  - In both cases, update the last-pair register and clear the hold counter.
- REPEAT: set `o_HOLD`, clear the hold counter, push nothing.
- REJECT: pulse `o_ERROR`. The last-pair register and hold counter are unchanged.
- After PUSH, REPEAT or REJECT, go to WAIT_RELEASE. Return to IDLE only after `i_DATA_READY` is seen at 0, so a single long ready level is decoded exactly once.
- Hold counter:
  - Increments every cycle and saturates at `HOLD_WINDOW`.
  - Width is $clog2(`HOLD_WINDOW`+1).
  - It is at `HOLD_WINDOW` after reset, so the first frame is never a repeat.
- `o_HOLD` clears on the cycle the hold counter reaches `HOLD_WINDOW`, and also whenever a PUSH stores a different pair.
- FIFO:
  - First-word-fall-through: `o_ADDR`/`o_CMD` show the head entry whenever `o_CMD_VALID`=1.
  - A pop is effective only when `i_CMD_POP`=1 and `o_CMD_VALID`=1; `i_CMD_POP` while empty is ignored.
  - A push and a pop in the same cycle both succeed, including when the FIFO is full.
  - Pointers wrap modulo `FIFO_DEPTH`. An extra pointer bit distinguishes full from empty.

## Timing
- Reset values:
  - State: IDLE.
  - FIFO: empty.
  - `o_CMD_VALID`, `o_HOLD`, `o_ERROR`, `o_OVERFLOW`: 0.
  - `o_ADDR`, `o_CMD`: 0.
  - Last-pair register: 0.
  - Hold counter: `HOLD_WINDOW`.
- Cycle sequence when `i_DATA_READY` is sampled high at edge N in IDLE:
  - Edge N: capture the frame.
  - Edge N+1: CHECK.
  - Edge N+2: write the FIFO, or register the `o_ERROR` / `o_OVERFLOW` / `o_HOLD` update.
  - `o_CMD_VALID` is high after edge N+2 if the FIFO was empty.
- `o_ERROR` and `o_OVERFLOW` are registered and last exactly one cycle.
- The pop takes effect at the clock edge; the next entry, or `o_CMD_VALID`=0, is visible after that edge.
- `i_DATA_READY` dropping during CHECK or PUSH does not abort the frame; WAIT_RELEASE then exits on the next edge.
- Reset asserted mid-frame returns every register to its reset value immediately (asynchronous). The partial frame is lost.

## Structure
- Package `ir_pkg`:
  - FSM state encoding typedef.
  - NEC byte-field index constants.
  - Default `HOLD_WINDOW`.
- Sub-module `ir_cmd_fifo`:
  - Parameterised width (16) and depth.
  - Push, pop, full and empty.
  - Same clock and asynchronous active-low reset as the top.
- The FSM, frame checks and hold counter stay in the top.

## Test plan
- Valid frame 32'hEF10_FB04 (cmd 10, addr 04): `o_CMD_VALID` high 3 cycles after ready is sampled; `o_ADDR`=8'h04, `o_CMD`=8'h10; a pop empties the FIFO.
- Command complement corrupt (32'hEE10_FB04): `o_ERROR` pulses for 1 cycle; FIFO stays empty; `o_HOLD` stays 0.
- Same valid frame twice, 1000 cycles apart, with `HOLD_WINDOW`=5000: one FIFO entry; `o_HOLD` high after the second frame; `o_HOLD` falls 5000 cycles after the second frame.
- Five valid distinct frames with no pops, `FIFO_DEPTH`=4: four entries in order; `o_OVERFLOW` pulses on the fifth; push and pop in the same cycle when full keeps the count at 4.
- `ADDR_MATCH_EN`=1, `ADDR_VALUE`=8'h04: a frame with address 8'h05 gives `o_ERROR`; a frame with address 8'h04 is accepted.
- Reset pulsed during CHECK, and `i_DATA_READY` held high for 100 cycles: reset clears everything; the held level yields exactly one decode.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR command decoder: FSM encoding, frame byte
// positions and the default key-hold window.
package ir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PUSH,
    ST_REPEAT,
    ST_REJECT,
    ST_WAIT_RELEASE
  } state_t;

  localparam int BYTE_W    = 8;
  localparam int ADDR_LSB  = 0;
  localparam int NADDR_LSB = 8;
  localparam int CMD_LSB   = 16;
  localparam int NCMD_LSB  = 24;

  // 120 ms at 50 MHz
  localparam int HOLD_WINDOW_DEFAULT = 6000000;

endpackage

// File: rtl/ir_command_decoder_if.sv
// Frame input, FIFO pop handshake and status outputs of the IR command decoder.
interface ir_command_decoder_if;

  logic        i_DATA_READY;
  logic [31:0] i_DATA;
  logic        i_CMD_POP;
  logic        o_CMD_VALID;
  logic [7:0]  o_ADDR;
  logic [7:0]  o_CMD;
  logic        o_HOLD;
  logic        o_ERROR;
  logic        o_OVERFLOW;

  modport master (
    output i_DATA_READY, i_DATA, i_CMD_POP,
    input  o_CMD_VALID, o_ADDR, o_CMD, o_HOLD, o_ERROR, o_OVERFLOW
  );

  modport slave (
    input  i_DATA_READY, i_DATA, i_CMD_POP,
    output o_CMD_VALID, o_ADDR, o_CMD, o_HOLD, o_ERROR, o_OVERFLOW
  );

endinterface

// File: rtl/ir_cmd_fifo.sv
// First-word-fall-through FIFO for decoded {address, command} pairs; a push
// into a full FIFO still lands when a pop happens on the same edge.
module ir_cmd_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] pop_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop_eff;
  logic             push_eff;

  // Extra MSB on each pointer separates full (MSBs differ) from empty.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_eff)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ir_command_decoder.sv
// Validates NEC frames from the IR receiver, folds key-hold repeats into a
// hold flag, and queues accepted {address, command} pairs for the host.
module ir_command_decoder
  import ir_pkg::*;
#(
  parameter bit         ADDR_CHECK    = 1'b1,
  parameter bit         ADDR_MATCH_EN = 1'b0,
  parameter logic [7:0] ADDR_VALUE    = 8'h00,
  parameter int         HOLD_WINDOW   = HOLD_WINDOW_DEFAULT,
  parameter int         FIFO_DEPTH    = 4
) (
  input logic                 i_CLOCK_POS,
  input logic                 i_RESET_NEG,
  ir_command_decoder_if.slave bus
);

  localparam int                CNT_W    = $clog2(HOLD_WINDOW + 1);
  localparam logic [CNT_W-1:0]  HOLD_MAX = CNT_W'(HOLD_WINDOW);

  state_t              state;
  state_t              state_nxt;
  logic [31:0]         frame;
  logic [BYTE_W-1:0]   f_addr;
  logic [BYTE_W-1:0]   f_naddr;
  logic [BYTE_W-1:0]   f_cmd;
  logic [BYTE_W-1:0]   f_ncmd;
  logic [15:0]         pair;
  logic [15:0]         last_pair;
  logic                frame_ok;
  logic                is_repeat;
  logic [CNT_W-1:0]    hold_cnt;
  logic [CNT_W-1:0]    hold_cnt_nxt;
  logic                capture;
  logic                do_push;
  logic                do_repeat;
  logic                do_reject;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop_eff;
  logic [15:0]         head;

  assign f_addr  = frame[ADDR_LSB  +: BYTE_W];
  assign f_naddr = frame[NADDR_LSB +: BYTE_W];
  assign f_cmd   = frame[CMD_LSB   +: BYTE_W];
  assign f_ncmd  = frame[NCMD_LSB  +: BYTE_W];
  assign pair    = {f_addr, f_cmd};

  assign frame_ok  = (f_ncmd == ~f_cmd)
                  && (!ADDR_CHECK    || (f_naddr == ~f_addr))
                  && (!ADDR_MATCH_EN || (f_addr == ADDR_VALUE));
  assign is_repeat = (pair == last_pair) && (hold_cnt < HOLD_MAX);

  always_ff @(posedge i_CLOCK_POS or negedge i_RESET_NEG) begin
    if (!i_RESET_NEG) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:         if (bus.i_DATA_READY) state_nxt = ST_CHECK;
      ST_CHECK:        if (!frame_ok)        state_nxt = ST_REJECT;
                       else if (is_repeat)   state_nxt = ST_REPEAT;
                       else                  state_nxt = ST_PUSH;
      ST_PUSH,
      ST_REPEAT,
      ST_REJECT:       state_nxt = ST_WAIT_RELEASE;
      // A long ready level must be seen low before the next frame is taken.
      ST_WAIT_RELEASE: if (!bus.i_DATA_READY) state_nxt = ST_IDLE;
      default:         state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    capture   = 1'b0;
    do_push   = 1'b0;
    do_repeat = 1'b0;
    do_reject = 1'b0;
    case (state)
      ST_IDLE:   capture   = bus.i_DATA_READY;
      ST_PUSH:   do_push   = 1'b1;
      ST_REPEAT: do_repeat = 1'b1;
      ST_REJECT: do_reject = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge i_CLOCK_POS) begin
    if (capture) frame <= bus.i_DATA;
  end

  always_comb begin
    if (do_push || do_repeat)   hold_cnt_nxt = '0;
    else if (hold_cnt < HOLD_MAX) hold_cnt_nxt = hold_cnt + CNT_W'(1);
    else                        hold_cnt_nxt = hold_cnt;
  end

  assign pop_eff = bus.i_CMD_POP && !fifo_empty;

  // Counter starts saturated so the first frame after reset is never a repeat.
  always_ff @(posedge i_CLOCK_POS or negedge i_RESET_NEG) begin
    if (!i_RESET_NEG) begin
      hold_cnt       <= HOLD_MAX;
      last_pair      <= '0;
      bus.o_HOLD     <= 1'b0;
      bus.o_ERROR    <= 1'b0;
      bus.o_OVERFLOW <= 1'b0;
    end else begin
      hold_cnt       <= hold_cnt_nxt;
      bus.o_ERROR    <= do_reject;
      bus.o_OVERFLOW <= do_push && fifo_full && !pop_eff;
      if (do_push) last_pair <= pair;
      if (do_repeat)                           bus.o_HOLD <= 1'b1;
      else if (do_push && (pair != last_pair)) bus.o_HOLD <= 1'b0;
      else if (hold_cnt_nxt == HOLD_MAX)       bus.o_HOLD <= 1'b0;
    end
  end

  ir_cmd_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_CLOCK_POS),
    .rst_n     (i_RESET_NEG),
    .push      (do_push),
    .push_data (pair),
    .pop       (bus.i_CMD_POP),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .pop_data  (head)
  );

  // Head is masked while empty so the outputs read zero out of reset.
  assign bus.o_CMD_VALID = !fifo_empty;
  assign bus.o_ADDR      = fifo_empty ? '0 : head[15:8];
  assign bus.o_CMD       = fifo_empty ? '0 : head[7:0];

endmodule
